// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one physical-memory line port between the icache and dcache paths.
// Latency: pmem strobe 1 cycle after grant in IDLE; owner resp 1 cycle after pmem_resp.
// Backpressure: one transaction at a time; the loser holds its request, round-robin on contention.
module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

   // Owner / priority encoding: 1 means dcache, 0 means icache.
   localparam logic OWN_D = 1'b1;

   state_t            state;
   state_t            state_nxt;
   logic              owner;
   logic              owner_nxt;
   logic              prio;
   logic              prio_nxt;
   logic              pmem_read_nxt;
   logic              pmem_write_nxt;
   logic [ADDR_W-1:0] pmem_addr_nxt;
   logic [LINE_W-1:0] pmem_wdata_nxt;
   logic [LINE_W-1:0] i_rdata_nxt;
   logic [LINE_W-1:0] d_rdata_nxt;
   logic              i_resp_nxt;
   logic              d_resp_nxt;

   logic              i_req;
   logic              d_req;
   logic              grant_d;

   // A dcache read+write together is a writeback, so any dcache strobe counts as a request.
   assign i_req   = i_read;
   assign d_req   = d_read | d_write;
   assign grant_d = d_req & (~i_req | (prio == OWN_D));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: GAP is a dead cycle so a just-served owner can drop its request.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_req || d_req) state_nxt = BUSY;
         BUSY:    if (pmem_resp)      state_nxt = RESP;
         RESP:    state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output/datapath next values: latch the grant in IDLE, complete the transaction in BUSY.
   always_comb begin
      owner_nxt      = owner;
      prio_nxt       = prio;
      pmem_read_nxt  = pmem_read;
      pmem_write_nxt = pmem_write;
      pmem_addr_nxt  = pmem_addr;
      pmem_wdata_nxt = pmem_wdata;
      i_rdata_nxt    = i_rdata;
      d_rdata_nxt    = d_rdata;
      i_resp_nxt     = 1'b0;
      d_resp_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               owner_nxt      = grant_d;
               pmem_addr_nxt  = grant_d ? d_addr : i_addr;
               pmem_write_nxt = grant_d & d_write;
               pmem_read_nxt  = ~(grant_d & d_write);
               if (grant_d) begin
                  pmem_wdata_nxt = d_wdata;
               end
            end
         end
         BUSY: begin
            if (pmem_resp) begin
               pmem_read_nxt  = 1'b0;
               pmem_write_nxt = 1'b0;
               prio_nxt       = ~owner;
               if (owner == OWN_D) begin
                  d_resp_nxt = 1'b1;
                  if (!pmem_write) begin
                     d_rdata_nxt = pmem_rdata;
                  end
               end else begin
                  i_resp_nxt  = 1'b1;
                  i_rdata_nxt = pmem_rdata;
               end
            end
         end
         default: ;
      endcase
   end

   // Output and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner      <= 1'b0;
         prio       <= OWN_D;
         pmem_read  <= 1'b0;
         pmem_write <= 1'b0;
         pmem_addr  <= '0;
         pmem_wdata <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_resp     <= 1'b0;
         d_resp     <= 1'b0;
      end else begin
         owner      <= owner_nxt;
         prio       <= prio_nxt;
         pmem_read  <= pmem_read_nxt;
         pmem_write <= pmem_write_nxt;
         pmem_addr  <= pmem_addr_nxt;
         pmem_wdata <= pmem_wdata_nxt;
         i_rdata    <= i_rdata_nxt;
         d_rdata    <= d_rdata_nxt;
         i_resp     <= i_resp_nxt;
         d_resp     <= d_resp_nxt;
      end
   end

endmodule
